wiggle_gen: RTL and testbench
=============================

Name: wiggle_gen

Overview:
Parametrised successor to the board-level LED/GPIO wiggler used in board bring-up. It drives the LED bank and the GPIO header from a prescaled tick. Four selectable LED patterns are supported, and the GPIO free-running counter keeps its behaviour. It sits at the top of bring-up builds, directly on the FPGA pins.

Parameters:
LED_W, 8, LED bank width; must be >= 2.
GPIO_W, 27, GPIO bank width; must be >= LED_W.
DIV_W, 24, width of the runtime prescale divisor.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
en  in  1  run enable; 0 freezes all state.
mode  in  2  LED pattern select: 0 count, 1 walk, 2 bounce, 3 mirror.
div  in  DIV_W  prescale divisor; tick period is div+1 enabled cycles.
led  out  LED_W  LED pattern, registered.
gpio  out  GPIO_W  free-running tick counter, registered.
tick  out  1  one-cycle pulse on each pattern step, registered.

Behaviour:
- Reset, sampled at the clk edge while rst=1:
  - pc (prescale count) = 0, gpio = 0, led = 0, tick = 0.
  - act_mode = 0, dir = up.
  - rst dominates en and all other inputs.
  - Reset mid-run discards the current pattern; the first step after release occurs div+1 enabled edges later.
- Prescaler:
  - On an edge with en=1, if pc >= div: pc <= 0, tick <= 1, and a step occurs. Otherwise pc <= pc+1 and tick <= 0.
  - The >= comparison means lowering div below the current pc steps on the next enabled edge, with no wrap-around lockout.
  - div=0 gives tick=1 on every enabled edge.
- en=0: pc, led, gpio, act_mode and dir all hold; tick <= 0.
- Step, on the same edge that sets tick:
  - gpio <= gpio+1, wrapping from 2^GPIO_W-1 to 0, in every mode.
  - If mode != act_mode: act_mode <= mode and led loads the seed for the new mode (see list below); no pattern step occurs on that tick.
  - Otherwise led steps according to act_mode (see list below).
  - mode is sampled only on ticks; changes between ticks are invisible until the next tick.
- Modes (step rule; seed loaded on mode change):
  - mode 0 count: led <= led+1, wrapping from all-ones to 0. Seed 0.
  - mode 1 walk: rotate left, with led[LED_W-1] moving to bit 0. Seed 1. A non-one-hot value in led is simply rotated.
  - mode 2 bounce: one-hot moving toward the MSB while dir=up, toward bit 0 while dir=down.
    - Arriving at the MSB sets dir=down; arriving at bit 0 sets dir=up. Each end is shown for exactly one tick.
    - Seed is 1 with dir=up.
    - The period is 2*(LED_W-1) ticks.
  - mode 3 mirror: led <= upper LED_W bits of the post-increment gpio value. The seed is the same value, so mirror tracks gpio immediately.
- Latency: led, gpio and tick all change on the same edge. The first step after reset release with en=1 occurs on the (div+1)-th edge.
- Simultaneous events:
  - rst=1 together with pc >= div: reset wins; tick=0.
  - en falling on the edge where the step would occur: no step.
  - A mode change and a div change on the same tick: the seed is loaded, and the new div governs the next period.

Test Plan:
- div=3, mode=0, en=1 after reset -> tick pulses every 4 cycles; after 4 ticks led=4 and gpio=4; first tick on the 4th edge after rst falls.
- mode=1, div=0 -> first tick loads led=0x01; next ticks 0x02, 0x04 ... 0x80, then 0x01 (rotate wrap).
- mode=2, div=0 -> after seed: 0x02 ... 0x80, 0x40 ... 0x01, 0x02. Each end held exactly one tick; period 14 ticks.
- div=100 with pc around 50, then div changed to 10 -> tick on the next enabled edge, then every 11 cycles.
- en toggled low for 20 cycles mid-period -> led, gpio and pc frozen and tick=0; the step completes after the remaining count.
- rst pulsed mid-bounce (mode=2) -> led=0, gpio=0, act_mode=0. The first tick after release loads the seed 0x01 because mode (2) != act_mode (0); gpio=1 at that tick.
- Preload gpio near 2^27-1 via many ticks (or a GPIO_W=4 instance), mode=3 -> gpio wraps to 0 and led follows gpio[GPIO_W-1 -: LED_W].

Source files
------------

// File: rtl/wiggle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : wiggle_gen
//  Description : Prescaled LED/GPIO wiggler for board bring-up. Drives a
//                selectable LED pattern and a free-running GPIO tick counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module wiggle_gen #(
    parameter int LED_W  = 8,
    parameter int GPIO_W = 27,
    parameter int DIV_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    output logic [LED_W-1:0]  led,
    output logic [GPIO_W-1:0] gpio,
    output logic              tick
);

    localparam logic [1:0] c_mode_count  = 2'd0;
    localparam logic [1:0] c_mode_walk   = 2'd1;
    localparam logic [1:0] c_mode_bounce = 2'd2;
    localparam logic [1:0] c_mode_mirror = 2'd3;

    localparam logic [LED_W-1:0]  c_led_one  = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [GPIO_W-1:0] c_gpio_one = {{(GPIO_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]  c_pc_one   = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [DIV_W-1:0]  pc_q,       pc_d;
    logic [LED_W-1:0]  led_q,      led_d;
    logic [GPIO_W-1:0] gpio_q,     gpio_d;
    logic              tick_q,     tick_d;
    logic [1:0]        act_mode_q, act_mode_d;
    dir_e              dir_q,      dir_d;

    logic [GPIO_W-1:0] w_gpio_inc;
    logic [LED_W-1:0]  w_mirror;
    logic              w_step;

    assign w_gpio_inc = gpio_q + c_gpio_one;
    assign w_mirror   = w_gpio_inc[GPIO_W-1 -: LED_W];
    // >= rather than == so shrinking div below the running count steps at once
    assign w_step     = en && (pc_q >= div);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            led_q      <= '0;
            gpio_q     <= '0;
            tick_q     <= 1'b0;
            act_mode_q <= c_mode_count;
            dir_q      <= DIR_UP;
        end else begin
            pc_q       <= pc_d;
            led_q      <= led_d;
            gpio_q     <= gpio_d;
            tick_q     <= tick_d;
            act_mode_q <= act_mode_d;
            dir_q      <= dir_d;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        led_d      = led_q;
        gpio_d     = gpio_q;
        tick_d     = 1'b0;
        act_mode_d = act_mode_q;
        dir_d      = dir_q;

        if (w_step) begin
            pc_d   = '0;
            tick_d = 1'b1;
            gpio_d = w_gpio_inc;
            if (mode != act_mode_q) begin
                // A mode change only seeds the new pattern; stepping resumes next tick
                act_mode_d = mode;
                dir_d      = DIR_UP;
                case (mode)
                    c_mode_count:  led_d = '0;
                    c_mode_walk:   led_d = c_led_one;
                    c_mode_bounce: led_d = c_led_one;
                    default:       led_d = w_mirror;
                endcase
            end else begin
                case (act_mode_q)
                    c_mode_count: led_d = led_q + c_led_one;
                    c_mode_walk:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                    c_mode_bounce: begin
                        if (dir_q == DIR_UP) begin
                            led_d = led_q << 1;
                            if (led_d[LED_W-1]) begin
                                dir_d = DIR_DOWN;
                            end
                        end else begin
                            led_d = led_q >> 1;
                            if (led_d[0]) begin
                                dir_d = DIR_UP;
                            end
                        end
                    end
                    c_mode_mirror: led_d = w_mirror;
                    default:       led_d = led_q;
                endcase
            end
        end else if (en) begin
            pc_d = pc_q + c_pc_one;
        end
    end

    assign led  = led_q;
    assign gpio = gpio_q;
    assign tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_wiggle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wiggle_gen
//  Description : Directed self-checking bench for wiggle_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wiggle_gen;

    localparam int LED_W  = 8;
    localparam int GPIO_W = 27;
    localparam int DIV_W  = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              en;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  div;
    logic [LED_W-1:0]  led;
    logic [GPIO_W-1:0] gpio;
    logic              tick;

    logic       s_en;
    logic [1:0] s_mode;
    logic [3:0] s_div;
    logic [3:0] s_led;
    logic [5:0] s_gpio;
    logic       s_tick;

    int n_assert = 0;
    int n_fail   = 0;

    logic [GPIO_W-1:0] exp_gpio;
    logic [5:0]        g;
    logic [7:0]        wseq [8];
    logic [7:0]        bseq [15];

    wiggle_gen #(.LED_W(LED_W), .GPIO_W(GPIO_W), .DIV_W(DIV_W)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .div  (div),
        .led  (led),
        .gpio (gpio),
        .tick (tick)
    );

    wiggle_gen #(.LED_W(4), .GPIO_W(6), .DIV_W(4)) u_small (
        .clk  (clk),
        .rst  (rst),
        .en   (s_en),
        .mode (s_mode),
        .div  (s_div),
        .led  (s_led),
        .gpio (s_gpio),
        .tick (s_tick)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        wseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        bseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        rst = 1'b1; en = 1'b0; mode = 2'd0; div = 24'd3;
        s_en = 1'b0; s_mode = 2'd0; s_div = 4'd0;
        cyc();
        cyc();
        chk("rst_led",    64'(led),    64'h0);
        chk("rst_gpio",   64'(gpio),   64'h0);
        chk("rst_tick",   64'(tick),   64'h0);
        chk("rst_s_led",  64'(s_led),  64'h0);
        chk("rst_s_gpio", 64'(s_gpio), 64'h0);

        // Count mode, div=3: a tick on every 4th edge
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                cyc();
                chk("cnt_idle", 64'(tick), 64'h0);
            end
            cyc();
            chk("cnt_tick", 64'(tick), 64'h1);
            chk("cnt_led",  64'(led),  64'(k));
            chk("cnt_gpio", 64'(gpio), 64'(k));
        end
        exp_gpio = 27'd4;

        // Walk mode, div=0: seed then rotate with wrap
        mode = 2'd1; div = '0;
        cyc();
        exp_gpio++;
        chk("walk_seed", 64'(led),  64'h01);
        chk("walk_gpio", 64'(gpio), 64'(exp_gpio));
        for (int i = 0; i < 8; i++) begin
            cyc();
            exp_gpio++;
            chk("walk_led",  64'(led),  64'(wseq[i]));
            chk("walk_tick", 64'(tick), 64'h1);
        end
        chk("walk_gpio_end", 64'(gpio), 64'(exp_gpio));

        // Bounce mode, div=0: seed, then full period plus one
        mode = 2'd2;
        cyc();
        exp_gpio++;
        chk("bnc_seed", 64'(led), 64'h01);
        for (int i = 0; i < 15; i++) begin
            cyc();
            exp_gpio++;
            chk("bnc_led",  64'(led),  64'(bseq[i]));
            chk("bnc_gpio", 64'(gpio), 64'(exp_gpio));
        end

        // div=100 for 50 edges, then lower to 10: immediate step
        div = 24'd100;
        for (int i = 0; i < 50; i++) begin
            cyc();
            chk("div_big_idle", 64'(tick), 64'h0);
        end
        chk("div_big_led", 64'(led), 64'h02);
        div = 24'd10;
        cyc();
        exp_gpio++;
        chk("div_drop_tick", 64'(tick), 64'h1);
        chk("div_drop_led",  64'(led),  64'h04);
        chk("div_drop_gpio", 64'(gpio), 64'(exp_gpio));
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("div10_idle", 64'(tick), 64'h0);
        end
        cyc();
        exp_gpio++;
        chk("div10_tick", 64'(tick), 64'h1);
        chk("div10_led",  64'(led),  64'h08);

        // Freeze with en=0 mid-period
        repeat (5) cyc();
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("frz_tick", 64'(tick), 64'h0);
            chk("frz_led",  64'(led),  64'h08);
            chk("frz_gpio", 64'(gpio), 64'(exp_gpio));
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("resume_idle", 64'(tick), 64'h0);
        end
        cyc();
        exp_gpio++;
        chk("resume_tick", 64'(tick), 64'h1);
        chk("resume_led",  64'(led),  64'h10);
        chk("resume_gpio", 64'(gpio), 64'(exp_gpio));

        // Reset on the very edge a step would occur
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        chk("rst_mid_tick", 64'(tick), 64'h0);
        chk("rst_mid_led",  64'(led),  64'h0);
        chk("rst_mid_gpio", 64'(gpio), 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("post_rst_idle", 64'(tick), 64'h0);
        end
        cyc();
        chk("post_rst_tick", 64'(tick), 64'h1);
        chk("post_rst_seed", 64'(led),  64'h01);
        chk("post_rst_gpio", 64'(gpio), 64'h1);
        repeat (10) cyc();
        cyc();
        chk("post_rst_step", 64'(led),  64'h02);
        chk("post_rst_g2",   64'(gpio), 64'h2);

        // Small instance, mirror mode: gpio wraps and led follows top bits
        s_mode = 2'd3; s_div = 4'd0; s_en = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            cyc();
            g = 6'(k);
            chk("mir_gpio", 64'(s_gpio), 64'(g));
            chk("mir_led",  64'(s_led),  64'(g[5:2]));
            chk("mir_tick", 64'(s_tick), 64'h1);
        end
        s_en = 1'b0;
        cyc();
        chk("mir_en_off_tick", 64'(s_tick), 64'h0);
        chk("mir_en_off_gpio", 64'(s_gpio), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
